// File: rtl/set_assoc_cache_if.sv
// Bundle of the CPU data port and the backing-memory req/ack port of the cache.
// The slave modport is the cache's view. The master modport is the CPU-plus-memory environment.
interface set_assoc_cache_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  Mem_read;
  logic                  Mem_write;
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] Data_in;
  logic                  Stall;
  logic [DATA_WIDTH-1:0] Data_out;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport slave (
    input  Mem_read, Mem_write, Address, Data_in, mem_rdata, mem_ack,
    output Stall, Data_out, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output Mem_read, Mem_write, Address, Data_in, mem_rdata, mem_ack,
    input  Stall, Data_out, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back / write-allocate cache with one-word lines.
// Replacement is per-set round-robin. Misses go through a write-back then fill handshake.
module set_assoc_cache #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 3,
  parameter int WAYS       = 2
) (
  input logic              clk,
  input logic              reset,
  set_assoc_cache_if.slave bus
);
  // state     | meaning
  // IDLE      | serve hits; on a miss latch the victim way
  // WRITEBACK | copy the dirty victim back to memory
  // ALLOCATE  | fill the victim from memory at Address
  localparam int SETS     = 2**INDEX_BITS;
  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS;
  localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;
  typedef logic [WAY_BITS-1:0] way_t;

  state_e                state_q, state_d;
  logic [WAYS-1:0]       valid_q [SETS];
  logic [WAYS-1:0]       valid_d [SETS];
  logic [WAYS-1:0]       dirty_q [SETS];
  logic [WAYS-1:0]       dirty_d [SETS];
  logic [TAG_BITS-1:0]   tag_q   [SETS][WAYS];
  logic [TAG_BITS-1:0]   tag_d   [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_d  [SETS][WAYS];
  way_t                  ptr_q   [SETS];
  way_t                  ptr_d   [SETS];
  way_t                  victim_q, victim_d;
  logic                  by_ptr_q, by_ptr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  req, hit, any_inv;
  way_t                  hit_way, inv_way, miss_victim, ptr_next;

  assign idx = bus.Address[INDEX_BITS-1:0];
  assign tag = bus.Address[ADDR_WIDTH-1:INDEX_BITS];
  assign req = bus.Mem_read | bus.Mem_write;

  // Descending scan so the lowest-numbered invalid way wins.
  always_comb begin : lookup
    hit     = 1'b0;
    hit_way = '0;
    any_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][WAY_BITS'(w)] && (tag_q[idx][WAY_BITS'(w)] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
      if (!valid_q[idx][WAY_BITS'(w)]) begin
        any_inv = 1'b1;
        inv_way = WAY_BITS'(w);
      end
    end
  end

  assign miss_victim = any_inv ? inv_way : ptr_q[idx];
  assign ptr_next    = (ptr_q[idx] == WAY_BITS'(WAYS - 1)) ? '0 : ptr_q[idx] + WAY_BITS'(1);

  always_ff @(posedge clk) begin : state_reg
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req && !hit) begin
          if (valid_q[idx][miss_victim] && dirty_q[idx][miss_victim]) state_d = WRITEBACK;
          else                                                        state_d = ALLOCATE;
        end
      end
      WRITEBACK: if (bus.mem_ack) state_d = ALLOCATE;
      ALLOCATE:  if (bus.mem_ack) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin : fsm_out
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state_q)
      WRITEBACK: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {tag_q[idx][victim_q], idx};
        bus.mem_wdata = data_q[idx][victim_q];
      end
      ALLOCATE: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = bus.Address;
      end
      default: ;
    endcase
  end

  assign bus.Stall    = req & ~((state_q == IDLE) & hit);
  assign bus.Data_out = rdata_q;

  always_comb begin : datapath
    valid_d  = valid_q;
    dirty_d  = dirty_q;
    tag_d    = tag_q;
    data_d   = data_q;
    ptr_d    = ptr_q;
    victim_d = victim_q;
    by_ptr_d = by_ptr_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (req && hit) begin
          if (bus.Mem_write) begin
            data_d[idx][hit_way]  = bus.Data_in;
            dirty_d[idx][hit_way] = 1'b1;
          end else begin
            rdata_d = data_q[idx][hit_way];
          end
        end else if (req) begin
          victim_d = miss_victim;
          by_ptr_d = !any_inv;
        end
      end
      WRITEBACK: if (bus.mem_ack) dirty_d[idx][victim_q] = 1'b0;
      ALLOCATE: begin
        if (bus.mem_ack) begin
          data_d[idx][victim_q]  = bus.mem_rdata;
          tag_d[idx][victim_q]   = tag;
          valid_d[idx][victim_q] = 1'b1;
          dirty_d[idx][victim_q] = 1'b0;
          if (by_ptr_q) ptr_d[idx] = ptr_next;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin : ctrl_regs
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
      victim_q <= '0;
      by_ptr_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
      ptr_q    <= ptr_d;
      victim_q <= victim_d;
      by_ptr_q <= by_ptr_d;
      rdata_q  <= rdata_d;
    end
  end

  // Tag and data storage has no reset; lines are qualified by valid.
  always_ff @(posedge clk) begin : array_regs
    if (!reset) begin
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end
endmodule

// File: tb/tb_set_assoc_cache.sv
// Bench for set_assoc_cache: a 2-way instance with 3-cycle memory and a direct-mapped one with 1-cycle memory.
// CPU results and backing-memory transactions are checked against queued expectations.
module tb_set_assoc_cache;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int L0 = 3;
  localparam int L1 = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  set_assoc_cache_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if0 ();
  set_assoc_cache_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();

  set_assoc_cache #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INDEX_BITS(3), .WAYS(2))
    dut0 (.clk(clk), .reset(reset), .bus(if0));
  set_assoc_cache #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INDEX_BITS(3), .WAYS(1))
    dut1 (.clk(clk), .reset(reset), .bus(if1));

  always #5 clk = ~clk;

  typedef struct { int stall; logic [DW-1:0] data; bit chk_data; } cpu_exp_t;
  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } mem_exp_t;

  cpu_exp_t      cpu_q[$];
  mem_exp_t      mq0[$];
  mem_exp_t      mq1[$];
  logic [DW-1:0] mem0 [1<<AW];
  logic [DW-1:0] mem1 [1<<AW];
  int            cnt0, cnt1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory models: ack arrives in the L-th cycle of a request.
  assign if0.mem_ack   = if0.mem_req && (cnt0 == L0 - 1);
  assign if0.mem_rdata = mem0[if0.mem_addr];
  assign if1.mem_ack   = if1.mem_req && (cnt1 == L1 - 1);
  assign if1.mem_rdata = mem1[if1.mem_addr];

  always @(posedge clk) begin
    if (reset)                             cnt0 <= 0;
    else if (if0.mem_req && !if0.mem_ack)  cnt0 <= cnt0 + 1;
    else                                   cnt0 <= 0;
    if (!reset && if0.mem_req && if0.mem_ack && if0.mem_we) mem0[if0.mem_addr] = if0.mem_wdata;
  end

  always @(posedge clk) begin
    if (reset)                             cnt1 <= 0;
    else if (if1.mem_req && !if1.mem_ack)  cnt1 <= cnt1 + 1;
    else                                   cnt1 <= 0;
    if (!reset && if1.mem_req && if1.mem_ack && if1.mem_we) mem1[if1.mem_addr] = if1.mem_wdata;
  end

  always @(negedge clk) begin
    mem_exp_t m;
    if (!reset && if0.mem_req && if0.mem_ack) begin
      chk("mem0_expected", mq0.size() > 0, 1);
      if (mq0.size() > 0) begin
        m = mq0.pop_front();
        chk("mem0_we", if0.mem_we, m.we);
        chk("mem0_addr", if0.mem_addr, m.addr);
        if (m.we) chk("mem0_wdata", if0.mem_wdata, m.wdata);
      end
    end
  end

  always @(negedge clk) begin
    mem_exp_t m;
    if (!reset && if1.mem_req && if1.mem_ack) begin
      chk("mem1_expected", mq1.size() > 0, 1);
      if (mq1.size() > 0) begin
        m = mq1.pop_front();
        chk("mem1_we", if1.mem_we, m.we);
        chk("mem1_addr", if1.mem_addr, m.addr);
        if (m.we) chk("mem1_wdata", if1.mem_wdata, m.wdata);
      end
    end
  end

  task automatic exp_mem(input int sel, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (sel == 0) mq0.push_back('{we, a, d});
    else          mq1.push_back('{we, a, d});
  endtask

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd);
    if (sel == 0) begin
      if0.Mem_read = rd; if0.Mem_write = wr; if0.Address = a; if0.Data_in = wd;
    end else begin
      if1.Mem_read = rd; if1.Mem_write = wr; if1.Address = a; if1.Data_in = wd;
    end
  endtask

  // Called just after a rising edge; returns just after the completing edge.
  task automatic cpu_op(input int sel, input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input int exp_stall,
                        input logic [DW-1:0] exp_data, input bit chk_data);
    cpu_exp_t      e;
    int            stalls;
    logic          st;
    logic [DW-1:0] dout;
    cpu_q.push_back('{exp_stall, exp_data, chk_data});
    drive(sel, rd, wr, a, wd);
    stalls = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      st = (sel == 0) ? if0.Stall : if1.Stall;
      if (!st) break;
      stalls++;
    end
    @(posedge clk);
    #1;
    dout = (sel == 0) ? if0.Data_out : if1.Data_out;
    drive(sel, 1'b0, 1'b0, a, wd);
    e = cpu_q.pop_front();
    chk($sformatf("stall_%0d_%03h", sel, a), stalls, e.stall);
    if (e.chk_data) chk($sformatf("rdata_%0d_%03h", sel, a), dout, e.data);
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) begin
      mem0[a] = 32'hA000_0000 + 32'(a);
      mem1[a] = 32'hA000_0000 + 32'(a);
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_stall", if0.Stall, 0);
    chk("rst_mem_req", if0.mem_req, 0);
    chk("rst_mem_we", if0.mem_we, 0);
    chk("rst_mem_addr", if0.mem_addr, 0);
    chk("rst_mem_wdata", if0.mem_wdata, 0);
    chk("rst_data_out", if0.Data_out, 0);
    chk("rst_mem_req1", if1.mem_req, 0);
    @(posedge clk);
    #1;

    // Fill into an empty set, then hit.
    exp_mem(0, 1'b0, 10'h003, '0);
    cpu_op(0, 1'b0, 1'b1, 10'h003, 32'h1234_5678, L0 + 1, '0, 1'b0);
    cpu_op(0, 1'b1, 1'b0, 10'h003, '0, 0, 32'h1234_5678, 1'b1);

    // Fill the second way, then evict dirty way 0 through the pointer.
    exp_mem(0, 1'b0, 10'h00B, '0);
    cpu_op(0, 1'b0, 1'b1, 10'h00B, 32'hAABB_CCDD, L0 + 1, '0, 1'b0);
    exp_mem(0, 1'b1, 10'h003, 32'h1234_5678);
    exp_mem(0, 1'b0, 10'h013, '0);
    cpu_op(0, 1'b0, 1'b1, 10'h013, 32'hFFFF_FFFF, 2 * L0 + 1, '0, 1'b0);
    cpu_op(0, 1'b1, 1'b0, 10'h013, '0, 0, 32'hFFFF_FFFF, 1'b1);
    cpu_op(0, 1'b1, 1'b0, 10'h00B, '0, 0, 32'hAABB_CCDD, 1'b1);

    // Clean read miss, then a hit.
    exp_mem(0, 1'b0, 10'h004, '0);
    cpu_op(0, 1'b1, 1'b0, 10'h004, '0, L0 + 1, 32'hA000_0004, 1'b1);
    cpu_op(0, 1'b1, 1'b0, 10'h004, '0, 0, 32'hA000_0004, 1'b1);

    // Read and write together: write wins, Data_out holds.
    cpu_op(0, 1'b1, 1'b1, 10'h00B, 32'h8765_4321, 0, 32'hA000_0004, 1'b1);
    cpu_op(0, 1'b1, 1'b0, 10'h00B, '0, 0, 32'h8765_4321, 1'b1);

    // Pointer is now 1: a miss in set 3 writes back 0x00B; reset aborts it.
    drive(0, 1'b1, 1'b0, 10'h01B, '0);
    @(negedge clk);
    chk("wb_entry_stall", if0.Stall, 1);
    @(posedge clk);
    @(negedge clk);
    chk("wb_req", if0.mem_req, 1);
    chk("wb_we", if0.mem_we, 1);
    chk("wb_addr", if0.mem_addr, 10'h00B);
    chk("wb_wdata", if0.mem_wdata, 32'h8765_4321);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 10'h01B, '0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_mem_req", if0.mem_req, 0);
    chk("abort_stall", if0.Stall, 0);
    chk("abort_mem_untouched", mem0[10'h00B], 32'hA000_000B);
    @(posedge clk);
    #1;
    exp_mem(0, 1'b0, 10'h00B, '0);
    cpu_op(0, 1'b1, 1'b0, 10'h00B, '0, L0 + 1, 32'hA000_000B, 1'b1);

    // Direct-mapped instance with single-cycle memory.
    exp_mem(1, 1'b0, 10'h003, '0);
    cpu_op(1, 1'b0, 1'b1, 10'h003, 32'h1111_1111, L1 + 1, '0, 1'b0);
    exp_mem(1, 1'b1, 10'h003, 32'h1111_1111);
    exp_mem(1, 1'b0, 10'h00B, '0);
    cpu_op(1, 1'b0, 1'b1, 10'h00B, 32'h2222_2222, 2 * L1 + 1, '0, 1'b0);
    cpu_op(1, 1'b1, 1'b0, 10'h00B, '0, 0, 32'h2222_2222, 1'b1);
    exp_mem(1, 1'b1, 10'h00B, 32'h2222_2222);
    exp_mem(1, 1'b0, 10'h003, '0);
    cpu_op(1, 1'b1, 1'b0, 10'h003, '0, 2 * L1 + 1, 32'h1111_1111, 1'b1);

    repeat (2) @(posedge clk);
    chk("mem0_left", mq0.size(), 0);
    chk("mem1_left", mq1.size(), 0);
    chk("cpu_left", cpu_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
